// File: rtl/efuse_ctrl_pkg.sv
// efuse_ctrl_pkg: shared state encoding, timing defaults and helpers for the eFuse Wishbone controller
package efuse_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_SENSE,
    WR_SCAN,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    ACK
  } state_e;
  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_PGM_CYCLES = 200;
  localparam int DEF_SENSE_CYCLES = 4;
  function automatic bit data_w_ok(input int w);
    return w == 8 || w == 32;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i+:8] = {8{sel[i]}};
    return m;
  endfunction
endpackage

// File: rtl/efuse_pulse_timer.sv
// efuse_pulse_timer: loadable down-counter; done_o flags the final cycle of a window
module efuse_pulse_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] load_val,
  output logic         done_o
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (count && cnt != '0) cnt <= cnt - 1'b1;
  assign done_o = cnt == W'(1);
endmodule

// File: rtl/efuse_wb_prog_ctrl.sv
// efuse_wb_prog_ctrl: Wishbone slave sequencing timed sense reads and bit-serial program pulses on an eFuse macro
module efuse_wb_prog_ctrl
  import efuse_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int PGM_CYCLES = DEF_PGM_CYCLES,
  parameter int SENSE_CYCLES = DEF_SENSE_CYCLES
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [DATA_W/8-1:0]       wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [DATA_W-1:0]         wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [DATA_W-1:0]         wbs_dat_o,
  output logic [ADDR_W-1:0]         ef_addr_o,
  output logic [$clog2(DATA_W)-1:0] ef_bit_o,
  output logic                      ef_pgm_o,
  output logic                      ef_sense_o,
  input  logic [DATA_W-1:0]         ef_dat_i,
  output logic                      busy_o
);
  localparam int BW = $clog2(DATA_W);
  localparam int TW = $clog2(max3(PGM_CYCLES, SETUP_CYCLES, SENSE_CYCLES) + 1);
  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("efuse_wb_prog_ctrl: DATA_W must be 8 or 32");
  end
  state_e state, next;
  logic [DATA_W-1:0] mask_q, req_mask;
  logic [31:0] sel_mask;
  logic [BW-1:0] idx;
  logic [TW-1:0] t_val;
  logic abort_q, t_done, t_load, req, last_bit, unused_adr;
  assign unused_adr = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};
  assign sel_mask = byte_mask(4'(wbs_sel_i));
  assign req_mask = wbs_dat_i & sel_mask[DATA_W-1:0];
  assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign last_bit = idx == BW'(DATA_W - 1);
  // every state change restarts the shared timer with the new window length
  assign t_load = next != state;
  assign t_val = next == WR_PULSE ? TW'(PGM_CYCLES) : next == RD_SENSE ? TW'(SENSE_CYCLES) : TW'(SETUP_CYCLES);
  efuse_pulse_timer #(.W(TW)) u_timer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .load    (t_load),
    .count   (state != IDLE),
    .load_val(t_val),
    .done_o  (t_done)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:     if (req) next = wbs_we_i ? (req_mask == '0 ? ACK : WR_SCAN) : RD_SETUP;
      RD_SETUP: next = !wbs_cyc_i ? IDLE : t_done ? RD_SENSE : RD_SETUP;
      RD_SENSE: next = !wbs_cyc_i ? IDLE : t_done ? ACK : RD_SENSE;
      WR_SCAN:  next = !wbs_cyc_i ? IDLE : mask_q[idx] ? WR_SETUP : last_bit ? ACK : WR_SCAN;
      WR_SETUP: next = !wbs_cyc_i ? IDLE : t_done ? WR_PULSE : WR_SETUP;
      // a started pulse always runs to full width regardless of the bus
      WR_PULSE: next = t_done ? WR_HOLD : WR_PULSE;
      WR_HOLD:  next = (abort_q || !wbs_cyc_i) ? IDLE : last_bit ? ACK : WR_SCAN;
      ACK:      next = IDLE;
      default:  next = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      wbs_ack_o  <= 1'b0;
      ef_pgm_o   <= 1'b0;
      ef_sense_o <= 1'b0;
      ef_addr_o  <= '0;
      ef_bit_o   <= '0;
      wbs_dat_o  <= '0;
      mask_q     <= '0;
      idx        <= '0;
      abort_q    <= 1'b0;
    end else begin
      state      <= next;
      busy_o     <= next != IDLE;
      wbs_ack_o  <= next == ACK;
      ef_pgm_o   <= next == WR_PULSE;
      ef_sense_o <= next == RD_SENSE;
      if (state == IDLE && req) begin
        ef_addr_o <= wbs_adr_i[ADDR_W+1:2];
        mask_q    <= req_mask;
        idx       <= '0;
      end
      if ((state == WR_SCAN || state == WR_HOLD) && next == WR_SCAN) idx <= idx + 1'b1;
      if (state == WR_SCAN && next == WR_SETUP) ef_bit_o <= idx;
      abort_q <= next != IDLE && (abort_q || (state == WR_PULSE && !wbs_cyc_i));
      if (state == RD_SENSE && next == ACK) wbs_dat_o <= ef_dat_i;
    end
endmodule

// File: tb/tb_efuse_wb_prog_ctrl.sv
// tb_efuse_wb_prog_ctrl: directed bench with a per-cycle timeline model of the eFuse controller
module tb_efuse_wb_prog_ctrl;
  localparam int S = 2, P = 200, SE = 4, SPH = S + P + 1, N = 1024;
  logic clk = 0, rst = 1, cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, dat_i = 0, ef_dat;
  logic ack, pgm, sense, busy;
  logic [31:0] dat_o;
  logic [9:0] ef_addr;
  logic [4:0] ef_bit;
  always #5 clk = ~clk;
  efuse_wb_prog_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .ef_addr_o(ef_addr), .ef_bit_o(ef_bit), .ef_pgm_o(pgm), .ef_sense_o(sense),
    .ef_dat_i(ef_dat), .busy_o(busy)
  );
  function automatic logic [31:0] macro_word(input logic [9:0] a);
    return a == 10'd4 ? 32'hA5A5_0F0F : (32'h1234_0000 | {22'd0, a});
  endfunction
  assign ef_dat = sense ? macro_word(ef_addr) : 32'h0;
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  bit e_pgm[N], e_sense[N], e_ack[N], e_busy[N], e_bv[N];
  logic [4:0] e_bit[N];
  logic [31:0] e_dat[N];
  logic [9:0] e_addr;
  logic [31:0] dat_prev = 0;
  int cur_k = 0;
  bit chk_on = 0;
  int ack_at, n_pgm, n_sense;
  int pb[$];
  logic [9:0] addr_in_pulse;
  initial begin
    bit pgm_d = 0;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk($sformatf("pgm@%0d", cur_k), pgm, e_pgm[cur_k]);
        chk($sformatf("sense@%0d", cur_k), sense, e_sense[cur_k]);
        chk($sformatf("ack@%0d", cur_k), ack, e_ack[cur_k]);
        chk($sformatf("busy@%0d", cur_k), busy, e_busy[cur_k]);
        chk($sformatf("dat@%0d", cur_k), dat_o, e_dat[cur_k]);
        chk($sformatf("excl@%0d", cur_k), pgm & sense, 0);
        if (e_busy[cur_k]) chk($sformatf("addr@%0d", cur_k), ef_addr, e_addr);
        if (e_bv[cur_k]) chk($sformatf("bit@%0d", cur_k), ef_bit, e_bit[cur_k]);
        if (pgm) n_pgm++;
        if (pgm && !pgm_d) begin
          pb.push_back(int'(ef_bit));
          addr_in_pulse = ef_addr;
        end
        if (sense) n_sense++;
        if (ack && ack_at < 0) ack_at = cur_k;
      end
      pgm_d = pgm;
    end
  end
  // builds the expected timeline from the scan/pulse arithmetic, then drives one bus transaction
  task automatic run(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int abt, input int rst_at, input int len);
    logic [31:0] m, rd;
    int last, nb, scan, ps, pe, ack_c;
    for (int k = 0; k < N; k++) begin
      e_pgm[k] = 0; e_sense[k] = 0; e_ack[k] = 0; e_busy[k] = 0; e_bv[k] = 0;
      e_bit[k] = 0; e_dat[k] = dat_prev;
    end
    for (int i = 0; i < 4; i++) m[8*i+:8] = d[8*i+:8] & {8{s[i]}};
    e_addr = a[11:2];
    if (!w) begin
      rd = macro_word(a[11:2]);
      ack_c = S + SE + 1;
      last = (abt > 0 && abt <= S + SE) ? abt : ack_c;
      for (int k = S + 1; k <= S + SE; k++) if (k <= last) e_sense[k] = 1;
      if (last == ack_c) begin
        e_ack[ack_c] = 1;
        for (int k = ack_c; k < N; k++) e_dat[k] = rd;
      end
    end else begin
      ack_c = m == 0 ? 1 : 32 + $countones(m) * SPH + 1;
      last = abt > 0 ? abt : ack_c;
      nb = 0;
      for (int i = 0; i < 32; i++) if (m[i]) begin
        scan = 1 + i + nb * SPH;
        ps = scan + S + 1;
        pe = scan + S + P;
        if (abt == 0 || abt >= ps) begin
          for (int k = scan + 1; k <= pe; k++) begin e_bv[k] = 1; e_bit[k] = 5'(i); end
          for (int k = ps; k <= pe; k++) e_pgm[k] = 1;
        end
        if (abt >= ps && abt <= pe + 1) last = pe + 1;
        nb++;
      end
      if (abt == 0) e_ack[ack_c] = 1;
    end
    for (int k = 1; k <= last; k++) e_busy[k] = 1;
    if (rst_at > 0)
      for (int k = rst_at + 1; k < N; k++) begin
        e_pgm[k] = 0; e_sense[k] = 0; e_ack[k] = 0; e_busy[k] = 0; e_bv[k] = 0; e_dat[k] = 0;
      end
    dat_prev = e_dat[len];
    ack_at = -1; n_pgm = 0; n_sense = 0; pb.delete(); addr_in_pulse = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      cur_k = k;
      chk_on = 1;
      @(negedge clk);
      if (k == abt || k == rst_at || ack) begin cyc = 0; stb = 0; end
      rst = k == rst_at;
    end
    @(posedge clk);
    chk_on = 0;
  endtask
  function automatic int pbit(input int i);
    return pb.size() > i ? pb[i] : -1;
  endfunction
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_pgm", pgm, 0);
    chk("rst_sense", sense, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_addr", ef_addr, 0);
    chk("rst_bit", ef_bit, 0);
    rst = 0;
    run(0, 32'h10, 0, 4'hF, 0, 0, 10);
    chk("rd_ack_cycle", ack_at, 7);
    chk("rd_sense_len", n_sense, 4);
    chk("rd_data", dat_o, 32'hA5A5_0F0F);
    run(0, 32'h20, 0, 4'hF, 4, 0, 8);
    chk("rdab_ack", ack_at, -1);
    chk("rdab_sense_len", n_sense, 2);
    chk("rdab_data_kept", dat_o, 32'hA5A5_0F0F);
    run(1, 32'h04, 32'h0000_0005, 4'hF, 0, 0, 442);
    chk("w5_ack_cycle", ack_at, 439);
    chk("w5_pulses", pb.size(), 2);
    chk("w5_pgm_cycles", n_pgm, 400);
    chk("w5_bit0", pbit(0), 0);
    chk("w5_bit1", pbit(1), 2);
    chk("w5_addr", addr_in_pulse, 1);
    chk("w5_dat_kept", dat_o, 32'hA5A5_0F0F);
    run(1, 32'h08, 32'hFFFF_FFFF, 4'h0, 0, 0, 4);
    chk("wsel0_ack_cycle", ack_at, 1);
    chk("wsel0_pgm", n_pgm, 0);
    run(1, 32'h08, 32'h0000_0000, 4'hF, 0, 0, 4);
    chk("wdat0_ack_cycle", ack_at, 1);
    chk("wdat0_pgm", n_pgm, 0);
    run(1, 32'hFFFF_F00C, 32'h0100_0080, 4'h1, 0, 0, 240);
    chk("w80_ack_cycle", ack_at, 236);
    chk("w80_pulses", pb.size(), 1);
    chk("w80_bit", pbit(0), 7);
    chk("w80_addr", addr_in_pulse, 10'h003);
    run(1, 32'h04, 32'h0000_0005, 4'hF, 0, 103, 110);
    chk("wrst_ack", ack_at, -1);
    chk("wrst_pgm_cycles", n_pgm, 100);
    chk("wrst_busy", busy, 0);
    chk("wrst_pgm_low", pgm, 0);
    run(0, 32'h10, 0, 4'hF, 0, 0, 10);
    chk("rd2_ack_cycle", ack_at, 7);
    chk("rd2_data", dat_o, 32'hA5A5_0F0F);
    run(1, 32'h0C, 32'h0000_0003, 4'hF, 53, 0, 212);
    chk("wab_ack", ack_at, -1);
    chk("wab_pulses", pb.size(), 1);
    chk("wab_pgm_cycles", n_pgm, 200);
    chk("wab_bit", pbit(0), 0);
    chk("wab_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
